uart_rx_ovs: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_ovs.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and bit-level helpers
//
// Contents:
//   uart_rx_state_e - receiver FSM states (also the reference for uart_tx)
//   maj3            - 2-of-3 majority vote
//   calc_parity     - even parity of up to 16 bits, inverted when odd is set
package uart_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_start,
    e_data,
    e_parity,
    e_stop,
    e_brk_wait
  } uart_rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Callers zero-extend narrower words; extra zeros do not change parity.
  function automatic logic calc_parity(input logic [15:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - divisor counter producing one oversample tick per div_i+1 clocks
//
// Ports:
//   clk_i      clock
//   reset_n_i  synchronous active-low reset
//   restart_i  forces the counter to 0 (phase-aligns ticks to an event)
//   div_i      tick period minus 1, in clock cycles
//   tick_o     high for one cycle when the counter reaches div_i
module uart_baud_tick #(
  parameter int div_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   restart_i,
  input  logic [div_width_p-1:0] div_i,
  output logic                   tick_o
);

  logic [div_width_p-1:0] cnt_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || restart_i) begin
      cnt_r <= '0;
    end else if (cnt_r == div_i) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick_o = (cnt_r == div_i) && !restart_i;

endmodule

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampling UART receiver with majority vote and one-entry output register
//
// Ports:
//   clk_i, reset_n_i  clock, synchronous active-low reset
//   baud_div_i        oversample tick period minus 1 (change only while idle)
//   rx_i              asynchronous serial line, idle high, LSB first
//   data_o, v_o       received word and its valid; held until v_o & ready_and_i
//   ready_and_i       consumer accept
//   parity_err_o      parity mismatch for the held word
//   frame_err_o       a stop bit sampled low for the held word
//   break_o           one-cycle pulse on break detection
//   overrun_o         sticky: a frame was dropped while the holding register was full
//   err_clear_i       clears overrun_o
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int div_width_p   = 16,
  parameter int ovs_p         = 16,
  parameter int data_bits_p   = 8,
  parameter int parity_bit_p  = 0,
  parameter int parity_odd_p  = 0,
  parameter int stop_bits_p   = 1,
  parameter int sync_stages_p = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [div_width_p-1:0] baud_div_i,
  input  logic                   rx_i,
  output logic [data_bits_p-1:0] data_o,
  output logic                   v_o,
  input  logic                   ready_and_i,
  output logic                   parity_err_o,
  output logic                   frame_err_o,
  output logic                   break_o,
  output logic                   overrun_o,
  input  logic                   err_clear_i
);

  localparam int SW   = $clog2(ovs_p);
  localparam int MAXB = (data_bits_p > stop_bits_p) ? data_bits_p : stop_bits_p;
  localparam int BW   = $clog2(MAXB + 1);

  localparam logic [SW-1:0] S_LO  = SW'(ovs_p / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(ovs_p / 2);
  localparam logic [SW-1:0] S_HI  = SW'(ovs_p / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(ovs_p - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(data_bits_p - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(stop_bits_p - 1);

  logic [sync_stages_p-1:0] sync_r;
  logic                     prev_r;
  logic                     rx_s;

  uart_rx_state_e           state_r;
  logic [SW-1:0]            s_r;
  logic [BW-1:0]            b_r;
  logic [data_bits_p-1:0]   data_r;
  logic [1:0]               samp_r;
  logic                     perr_r, ferr_r, par_r, brk_r;

  logic [data_bits_p-1:0]   hold_data_r;
  logic                     hold_v_r, hold_perr_r, hold_ferr_r, ovr_r;

  logic tick, restart, fall, maj, mid_pt, end_pt, brk_cond, deliver;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync_r <= '1;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[sync_stages_p-2:0], rx_i};
      prev_r <= rx_s;
    end
  end

  assign rx_s = sync_r[sync_stages_p-1];
  assign fall = prev_r && !rx_s;

  // Ticks are phase-locked to the start edge; in e_brk_wait any low level
  // restarts the one-bit-time high qualification.
  assign restart = (state_r == e_idle) || ((state_r == e_brk_wait) && !rx_s);

  uart_baud_tick #(
    .div_width_p(div_width_p)
  ) u_tick (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .restart_i(restart),
    .div_i    (baud_div_i),
    .tick_o   (tick)
  );

  assign mid_pt   = (s_r == S_HI);
  assign end_pt   = (s_r == S_END);
  assign maj      = maj3(samp_r[0], samp_r[1], rx_s);
  assign brk_cond = (data_r == '0) && ((parity_bit_p == 0) || !par_r) && !maj;
  assign deliver  = (state_r == e_stop) && tick && mid_pt &&
                    (b_r == B_STOP_LAST) && !brk_cond;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      s_r     <= '0;
      b_r     <= '0;
      data_r  <= '0;
      samp_r  <= '0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      par_r   <= 1'b0;
      brk_r   <= 1'b0;
    end else begin
      brk_r <= 1'b0;
      if (tick && (s_r == S_LO))  samp_r[0] <= rx_s;
      if (tick && (s_r == S_MID)) samp_r[1] <= rx_s;
      unique case (state_r)
        e_idle: begin
          if (fall) begin
            state_r <= e_start;
            s_r     <= '0;
            b_r     <= '0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            par_r   <= 1'b0;
          end
        end
        e_start: begin
          if (tick) begin
            if (mid_pt && maj) begin
              state_r <= e_idle;  // line back high by mid-bit: a glitch
              s_r     <= '0;
            end else if (end_pt) begin
              state_r <= e_data;
              s_r     <= '0;
            end else begin
              s_r <= s_r + 1'b1;
            end
          end
        end
        e_data: begin
          if (tick) begin
            if (mid_pt) data_r <= {maj, data_r[data_bits_p-1:1]};
            if (end_pt) begin
              s_r <= '0;
              if (b_r == B_DATA_LAST) begin
                b_r     <= '0;
                state_r <= (parity_bit_p != 0) ? e_parity : e_stop;
              end else begin
                b_r <= b_r + 1'b1;
              end
            end else begin
              s_r <= s_r + 1'b1;
            end
          end
        end
        e_parity: begin
          if (tick) begin
            if (mid_pt) begin
              par_r  <= maj;
              perr_r <= maj ^ calc_parity(16'(data_r), parity_odd_p != 0);
            end
            if (end_pt) begin
              s_r     <= '0;
              state_r <= e_stop;
            end else begin
              s_r <= s_r + 1'b1;
            end
          end
        end
        e_stop: begin
          if (tick) begin
            if (mid_pt && (b_r == B_STOP_LAST)) begin
              // Final stop bit finishes half a bit early to absorb baud skew.
              s_r <= '0;
              b_r <= '0;
              if (brk_cond) begin
                brk_r   <= 1'b1;
                state_r <= e_brk_wait;
              end else begin
                state_r <= e_idle;
              end
            end else if (end_pt) begin
              s_r <= '0;
              b_r <= b_r + 1'b1;
            end else begin
              if (mid_pt && !maj) ferr_r <= 1'b1;
              s_r <= s_r + 1'b1;
            end
          end
        end
        e_brk_wait: begin
          if (!rx_s) begin
            s_r <= '0;
          end else if (tick) begin
            if (end_pt) begin
              state_r <= e_idle;
              s_r     <= '0;
            end else begin
              s_r <= s_r + 1'b1;
            end
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  // One-entry holding register: a consume in the completion cycle frees the slot.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hold_v_r    <= 1'b0;
      hold_data_r <= '0;
      hold_perr_r <= 1'b0;
      hold_ferr_r <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      if (deliver && (!hold_v_r || ready_and_i)) begin
        hold_v_r    <= 1'b1;
        hold_data_r <= data_r;
        hold_perr_r <= perr_r;
        hold_ferr_r <= ferr_r || !maj;
      end else if (hold_v_r && ready_and_i) begin
        hold_v_r <= 1'b0;
      end
      if (deliver && hold_v_r && !ready_and_i) begin
        ovr_r <= 1'b1;
      end else if (err_clear_i) begin
        ovr_r <= 1'b0;
      end
    end
  end

  assign data_o       = hold_data_r;
  assign v_o          = hold_v_r;
  assign parity_err_o = hold_perr_r;
  assign frame_err_o  = hold_ferr_r;
  assign break_o      = brk_r;
  assign overrun_o    = ovr_r;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - directed table-driven bench for uart_rx_ovs (8N1 and 8E1 instances)
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int BIT = 64;  // 16 ticks x (baud_div 3 + 1)

  logic        clk = 1'b0;
  logic        rst_n, rx, rx_p, ready, ready_p, err_clr;
  logic [15:0] baud_div;
  logic [7:0]  data, data_p;
  logic        v, perr, ferr, brk, ovr;
  logic        v_p, perr_p, ferr_p, brk_p, ovr_p;

  always #5 clk = ~clk;

  uart_rx_ovs dut (
    .clk_i(clk), .reset_n_i(rst_n), .baud_div_i(baud_div), .rx_i(rx),
    .data_o(data), .v_o(v), .ready_and_i(ready), .parity_err_o(perr),
    .frame_err_o(ferr), .break_o(brk), .overrun_o(ovr), .err_clear_i(err_clr)
  );

  uart_rx_ovs #(.parity_bit_p(1), .parity_odd_p(0)) dut_p (
    .clk_i(clk), .reset_n_i(rst_n), .baud_div_i(baud_div), .rx_i(rx_p),
    .data_o(data_p), .v_o(v_p), .ready_and_i(ready_p), .parity_err_o(perr_p),
    .frame_err_o(ferr_p), .break_o(brk_p), .overrun_o(ovr_p), .err_clear_i(err_clr)
  );

  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   hs_cnt = 0, brk_cnt = 0, v_rise = 0;
  logic v_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v && ready) hs_cnt = hs_cnt + 1;
    if (brk) brk_cnt = brk_cnt + 1;
    if (v && !v_q) v_rise = cyc;
    v_q = v;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    bit         sel;     // 0: 8N1 instance, 1: 8E1 instance
    logic [7:0] d;
    bit         par;     // parity bit driven (8E1 only)
    bit         stop;
    int         glitch;  // frame bit index to invert for one cycle, -1 none
    logic [7:0] exp_d;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic val);
    if (sel) rx_p = val;
    else     rx   = val;
  endtask

  // Called at posedge+1; returns at posedge+1 one bit time later.
  task automatic hold_bit(input bit sel, input logic val, input bit g);
    drive(sel, val);
    if (g) begin
      repeat (36) @(posedge clk);
      #1 drive(sel, ~val);
      @(posedge clk);
      #1 drive(sel, val);
      repeat (27) @(posedge clk);
      #1;
    end else begin
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par,
                            input bit stop, input int glitch);
    hold_bit(sel, 1'b0, glitch == 0);
    for (int i = 0; i < 8; i++) hold_bit(sel, d[i], glitch == i + 1);
    if (sel) hold_bit(sel, par, 1'b0);
    hold_bit(sel, stop, 1'b0);
    drive(sel, 1'b1);
  endtask

  task automatic pulse_ready(input bit sel);
    if (sel) ready_p = 1'b1;
    else     ready   = 1'b1;
    @(posedge clk);
    #1;
    ready   = 1'b0;
    ready_p = 1'b0;
  endtask

  initial begin
    int hs0, brk0, t0, lat;
    logic [7:0] c3;

    vecs[0]  = '{0, 8'hA5, 0, 1, -1, 8'hA5, 0, 0};
    vecs[1]  = '{0, 8'h3C, 0, 1, -1, 8'h3C, 0, 0};
    vecs[2]  = '{0, 8'h55, 0, 0, -1, 8'h55, 0, 1};
    vecs[3]  = '{0, 8'h00, 0, 1, -1, 8'h00, 0, 0};
    vecs[4]  = '{0, 8'h5A, 0, 1,  3, 8'h5A, 0, 0};
    vecs[5]  = '{0, 8'hA5, 0, 1,  6, 8'hA5, 0, 0};
    vecs[6]  = '{1, 8'h03, 1, 1, -1, 8'h03, 1, 0};
    vecs[7]  = '{1, 8'h03, 0, 1, -1, 8'h03, 0, 0};
    vecs[8]  = '{1, 8'h80, 1, 1, -1, 8'h80, 0, 0};
    vecs[9]  = '{1, 8'h80, 0, 0, -1, 8'h80, 1, 1};
    vecs[10] = '{0, 8'hFF, 0, 1, -1, 8'hFF, 0, 0};

    rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; ready = 1'b0; ready_p = 1'b0;
    err_clr = 1'b0; baud_div = 16'd3;
    repeat (4) @(posedge clk);
    #1;
    check("reset_v", 32'(v), 0);
    check("reset_data", 32'(data), 0);
    check("reset_errs", {28'd0, perr, ferr, brk, ovr}, 0);
    check("reset_v_p", 32'(v_p), 0);
    rst_n = 1'b1;
    repeat (BIT) @(posedge clk);
    #1;

    // 0xA5 with ready held high: single handshake, latency about 9.5 bits
    ready = 1'b1;
    hs0 = hs_cnt;
    t0 = cyc;
    send_frame(0, 8'hA5, 0, 1, -1);
    repeat (BIT) @(posedge clk);
    #1;
    check("a5_handshakes", 32'(hs_cnt - hs0), 1);
    check("a5_data", 32'(data), 32'h A5);
    check("a5_errs", {30'd0, perr, ferr}, 0);
    lat = v_rise - t0;
    tests = tests + 1;
    if (lat < 600 || lat > 625) begin
      fails = fails + 1;
      $display("FAIL a5_latency: got %0d cycles expected 600..625", lat);
    end

    // start-bit glitch of 20 cycles is rejected
    hs0 = hs_cnt;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("glitch_no_v", 32'(hs_cnt - hs0), 0);
    check("glitch_idle", 32'(dut.state_r), 32'(e_idle));
    send_frame(0, 8'h3C, 0, 1, -1);
    repeat (BIT) @(posedge clk);
    #1;
    check("post_glitch_hs", 32'(hs_cnt - hs0), 1);
    check("post_glitch_data", 32'(data), 32'h3C);
    ready = 1'b0;

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].par, vecs[i].stop, vecs[i].glitch);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("vec%0d_v", i), 32'(vecs[i].sel ? v_p : v), 1);
      check($sformatf("vec%0d_data", i), 32'(vecs[i].sel ? data_p : data), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_perr", i), 32'(vecs[i].sel ? perr_p : perr), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d_ferr", i), 32'(vecs[i].sel ? ferr_p : ferr), 32'(vecs[i].exp_ferr));
      pulse_ready(vecs[i].sel);
      check($sformatf("vec%0d_v_drop", i), 32'(vecs[i].sel ? v_p : v), 0);
      repeat (BIT) @(posedge clk);
      #1;
    end

    // break: 20 bit times low, one pulse, no data; then line recovers
    ready = 1'b1;
    hs0 = hs_cnt;
    brk0 = brk_cnt;
    rx = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    #1 rx = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("break_pulses", 32'(brk_cnt - brk0), 1);
    check("break_no_v", 32'(hs_cnt - hs0), 0);
    send_frame(0, 8'h81, 0, 1, -1);
    repeat (BIT) @(posedge clk);
    #1;
    check("post_break_hs", 32'(hs_cnt - hs0), 1);
    check("post_break_data", 32'(data), 32'h81);
    check("post_break_ferr", 32'(ferr), 0);
    ready = 1'b0;

    // overrun: second frame dropped while first is held
    send_frame(0, 8'h11, 0, 1, -1);
    repeat (BIT) @(posedge clk);
    #1;
    send_frame(0, 8'h22, 0, 1, -1);
    repeat (8) @(posedge clk);
    #1;
    check("ovr_v", 32'(v), 1);
    check("ovr_data_kept", 32'(data), 32'h11);
    check("ovr_flag", 32'(ovr), 1);
    pulse_ready(0);
    check("ovr_v_drop", 32'(v), 0);
    repeat (BIT) @(posedge clk);
    #1;
    check("ovr_sticky", 32'(ovr), 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("ovr_cleared", 32'(ovr), 0);

    // reset in the middle of data bit 4 aborts the frame
    c3 = 8'hC3;
    hold_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(0, c3[i], 1'b0);
    drive(0, c3[4]);
    repeat (32) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_v", 32'(v), 0);
    check("midrst_data", 32'(data), 0);
    check("midrst_idle", 32'(dut.state_r), 32'(e_idle));
    repeat (2 * BIT) @(posedge clk);
    #1;
    check("midrst_no_frame", 32'(v), 0);
    send_frame(0, c3, 0, 1, -1);
    repeat (4) @(posedge clk);
    #1;
    check("c3_v", 32'(v), 1);
    check("c3_data", 32'(data), 32'hC3);
    check("c3_errs", {30'd0, perr, ferr}, 0);
    pulse_ready(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
